// File: rtl/microwatt_mbox_pkg.sv
// Shared definitions for the Microwatt external-I/O debug mailbox:
// register offsets, STATUS/CTRL bit positions, the STATUS word layout
// and a helper that packs per-channel state into that word.
package microwatt_mbox_pkg;

   localparam int unsigned MBOX_MAX_CH = 8;
   localparam int unsigned MBOX_DW     = 32;

   // Register offsets within a channel (wb_adr[1:0])
   localparam logic [1:0] MBOX_TXDATA = 2'd0;
   localparam logic [1:0] MBOX_RXDATA = 2'd1;
   localparam logic [1:0] MBOX_STATUS = 2'd2;
   localparam logic [1:0] MBOX_CTRL   = 2'd3;

   // STATUS bit positions
   localparam int unsigned STAT_TX_FULL  = 0;
   localparam int unsigned STAT_TX_EMPTY = 1;
   localparam int unsigned STAT_RX_FULL  = 2;
   localparam int unsigned STAT_RX_EMPTY = 3;
   localparam int unsigned STAT_TX_OVF   = 4;
   localparam int unsigned STAT_RX_UNF   = 5;
   localparam int unsigned STAT_RX_CNT   = 8;
   localparam int unsigned STAT_TX_CNT   = 16;

   // CTRL bit positions
   localparam int unsigned CTRL_RX_IRQ_EN = 0;
   localparam int unsigned CTRL_FLUSH     = 1;
   localparam int unsigned CTRL_CLR_ERR   = 2;

   localparam int unsigned MBOX_CNT_FIELD_W = 7;

   // STATUS register layout, MSB first
   typedef struct packed {
      logic [8:0]                  rsvd_hi;
      logic [MBOX_CNT_FIELD_W-1:0] tx_count;
      logic                        rsvd_mid;
      logic [MBOX_CNT_FIELD_W-1:0] rx_count;
      logic [1:0]                  rsvd_lo;
      logic                        rx_unf;
      logic                        tx_ovf;
      logic                        rx_empty;
      logic                        rx_full;
      logic                        tx_empty;
      logic                        tx_full;
   } mbox_status_t;

   function automatic logic [MBOX_DW-1:0] mbox_status(
      input logic                        tx_full,
      input logic                        tx_empty,
      input logic                        rx_full,
      input logic                        rx_empty,
      input logic                        tx_ovf,
      input logic                        rx_unf,
      input logic [MBOX_CNT_FIELD_W-1:0] rx_count,
      input logic [MBOX_CNT_FIELD_W-1:0] tx_count
   );
      mbox_status_t s;
      s          = '0;
      s.tx_full  = tx_full;
      s.tx_empty = tx_empty;
      s.rx_full  = rx_full;
      s.rx_empty = rx_empty;
      s.tx_ovf   = tx_ovf;
      s.rx_unf   = rx_unf;
      s.rx_count = rx_count;
      s.tx_count = tx_count;
      return MBOX_DW'(s);
   endfunction

endpackage

// File: rtl/mbox_sync_fifo.sv
// Single-clock FIFO used for each mailbox direction.
// Ports: clk/rst (sync, active-high); push/wr_data write side; pop read side;
// flush empties the FIFO and overrides push/pop; rd_data is the head word;
// count/full/empty report occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module mbox_sync_fifo #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [DATA_W-1:0]          wr_data,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push_c;
   logic              do_pop_c;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop_c  = pop & ~empty;
   // full is judged after a same-cycle pop
   assign do_push_c = push & (~full | do_pop_c);
   assign rd_data   = mem[rd_ptr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

   // Storage; contents are don't-care after reset or flush
   always_ff @(posedge clk) begin
      if (do_push_c && !flush) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/microwatt_ext_io_mailbox.sv
// Debug mailbox terminating Microwatt's wb_ext_io Wishbone port.
// Ports: ext_clk/ext_rst (sync, active-high); pipelined Wishbone slave
// (wb_adr[4:2]=channel, wb_adr[1:0]=register, ack one cycle after accept,
// never stalls); per-channel host TX stream (CPU->host) and host RX stream
// (host->CPU), channel c in bits [32c+31:32c]; irq = OR of channel RX irqs.
module microwatt_ext_io_mailbox
   import microwatt_mbox_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  ext_clk,
   input  logic                  ext_rst,
   input  logic [29:0]           wb_adr,
   input  logic [31:0]           wb_dat_w,
   input  logic [3:0]            wb_sel,
   input  logic                  wb_cyc,
   input  logic                  wb_stb,
   input  logic                  wb_we,
   output logic [31:0]           wb_dat_r,
   output logic                  wb_ack,
   output logic                  wb_stall,
   output logic [NUM_CH*32-1:0]  host_tx_data,
   output logic [NUM_CH-1:0]     host_tx_valid,
   input  logic [NUM_CH-1:0]     host_tx_ready,
   input  logic [NUM_CH*32-1:0]  host_rx_data,
   input  logic [NUM_CH-1:0]     host_rx_valid,
   output logic [NUM_CH-1:0]     host_rx_ready,
   output logic                  irq
);

   logic        acc_c;
   logic        wr_c;
   logic        rd_c;
   logic [2:0]  ch_idx;
   logic [1:0]  reg_sel;
   logic [31:0] rd_data_c;
   logic        unused_adr;

   logic [NUM_CH-1:0] ch_hit;
   logic [NUM_CH-1:0] tx_push, tx_pop, tx_full, tx_empty;
   logic [NUM_CH-1:0] rx_push, rx_pop, rx_full, rx_empty;
   logic [NUM_CH-1:0] flush, ctrl_wr;
   logic [NUM_CH-1:0] rx_irq_en, tx_ovf, rx_unf;
   logic [31:0]       tx_head [NUM_CH];
   logic [31:0]       rx_head [NUM_CH];
   logic [CNT_W-1:0]  tx_cnt  [NUM_CH];
   logic [CNT_W-1:0]  rx_cnt  [NUM_CH];

   assign acc_c      = wb_cyc & wb_stb;
   assign wr_c       = acc_c & wb_we & (|wb_sel);
   assign rd_c       = acc_c & ~wb_we;
   assign ch_idx     = wb_adr[4:2];
   assign reg_sel    = wb_adr[1:0];
   assign wb_stall   = 1'b0;
   assign unused_adr = ^wb_adr[29:5];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic irq_en_q;
      logic tx_ovf_q;
      logic rx_unf_q;

      // Out-of-range channel indices never match, so they have no side effect
      assign ch_hit[c]  = (ch_idx == 3'(c));
      assign tx_push[c] = wr_c & ch_hit[c] & (reg_sel == MBOX_TXDATA);
      assign rx_pop[c]  = rd_c & ch_hit[c] & (reg_sel == MBOX_RXDATA);
      assign ctrl_wr[c] = wr_c & ch_hit[c] & (reg_sel == MBOX_CTRL);
      assign flush[c]   = ctrl_wr[c] & wb_dat_w[CTRL_FLUSH];
      assign tx_pop[c]  = host_tx_valid[c] & host_tx_ready[c];
      assign rx_push[c] = host_rx_valid[c] & host_rx_ready[c];

      mbox_sync_fifo #(.DATA_W(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
         .clk     (ext_clk),
         .rst     (ext_rst),
         .push    (tx_push[c]),
         .pop     (tx_pop[c]),
         .flush   (flush[c]),
         .wr_data (wb_dat_w),
         .rd_data (tx_head[c]),
         .count   (tx_cnt[c]),
         .full    (tx_full[c]),
         .empty   (tx_empty[c])
      );

      mbox_sync_fifo #(.DATA_W(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
         .clk     (ext_clk),
         .rst     (ext_rst),
         .push    (rx_push[c]),
         .pop     (rx_pop[c]),
         .flush   (flush[c]),
         .wr_data (host_rx_data[32*c +: 32]),
         .rd_data (rx_head[c]),
         .count   (rx_cnt[c]),
         .full    (rx_full[c]),
         .empty   (rx_empty[c])
      );

      // Channel control: irq enable and sticky error flags
      always_ff @(posedge ext_clk) begin
         if (ext_rst) begin
            irq_en_q <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
         end else begin
            if (ctrl_wr[c]) begin
               irq_en_q <= wb_dat_w[CTRL_RX_IRQ_EN];
               if (wb_dat_w[CTRL_CLR_ERR]) begin
                  tx_ovf_q <= 1'b0;
                  rx_unf_q <= 1'b0;
               end
            end
            // A host pop in the same cycle frees the slot, so no overflow
            if (tx_push[c] && tx_full[c] && !tx_pop[c]) tx_ovf_q <= 1'b1;
            if (rx_pop[c] && rx_empty[c])               rx_unf_q <= 1'b1;
         end
      end

      assign rx_irq_en[c]             = irq_en_q;
      assign tx_ovf[c]                = tx_ovf_q;
      assign rx_unf[c]                = rx_unf_q;
      assign host_tx_data[32*c +: 32] = tx_head[c];
      assign host_tx_valid[c]         = ~tx_empty[c];
      assign host_rx_ready[c]         = ~rx_full[c];
   end

   assign irq = |(rx_irq_en & ~rx_empty);

   // Read-data mux; reflects state in the accept cycle
   always_comb begin
      rd_data_c = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (ch_hit[c]) begin
            case (reg_sel)
               MBOX_RXDATA: rd_data_c = rx_empty[c] ? 32'h0 : rx_head[c];
               MBOX_STATUS: rd_data_c = mbox_status(tx_full[c], tx_empty[c],
                                                    rx_full[c], rx_empty[c],
                                                    tx_ovf[c], rx_unf[c],
                                                    MBOX_CNT_FIELD_W'(rx_cnt[c]),
                                                    MBOX_CNT_FIELD_W'(tx_cnt[c]));
               MBOX_CTRL:   rd_data_c = 32'(rx_irq_en[c]);
               default:     rd_data_c = '0;
            endcase
         end
      end
   end

   // Ack and read data, one cycle after acceptance
   always_ff @(posedge ext_clk) begin
      if (ext_rst) begin
         wb_ack   <= 1'b0;
         wb_dat_r <= '0;
      end else begin
         wb_ack   <= acc_c;
         wb_dat_r <= rd_c ? rd_data_c : 32'h0;
      end
   end

endmodule

// File: tb/tb_microwatt_ext_io_mailbox.sv
// Self-checking bench for microwatt_ext_io_mailbox with a queue-based model.
module tb_microwatt_ext_io_mailbox;

   localparam int NCH = 4;
   localparam int DEP = 8;

   logic              ext_clk;
   logic              ext_rst;
   logic [29:0]       wb_adr;
   logic [31:0]       wb_dat_w;
   logic [3:0]        wb_sel;
   logic              wb_cyc, wb_stb, wb_we;
   logic [31:0]       wb_dat_r;
   logic              wb_ack, wb_stall;
   logic [NCH*32-1:0] host_tx_data;
   logic [NCH-1:0]    host_tx_valid, host_tx_ready;
   logic [NCH*32-1:0] host_rx_data;
   logic [NCH-1:0]    host_rx_valid, host_rx_ready;
   logic              irq;

   microwatt_ext_io_mailbox #(.NUM_CH(NCH), .FIFO_DEPTH(DEP)) dut (
      .ext_clk(ext_clk), .ext_rst(ext_rst),
      .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
      .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_stall(wb_stall),
      .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
      .host_tx_ready(host_tx_ready),
      .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
      .host_rx_ready(host_rx_ready),
      .irq(irq)
   );

   initial ext_clk = 1'b0;
   always #5 ext_clk = ~ext_clk;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int ack_cnt = 0;
   logic [31:0] last_rd;

   // Reference model: plain queues per channel plus flag bits
   logic [31:0] txq     [NCH][$];
   logic [31:0] rxq     [NCH][$];
   logic [31:0] dut_got [NCH][$];
   bit ovf [NCH];
   bit unf [NCH];
   bit ien [NCH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input int c);
      bit txf, txe, rxf, rxe;
      txf = (txq[c].size() == DEP);
      txe = (txq[c].size() == 0);
      rxf = (rxq[c].size() == DEP);
      rxe = (rxq[c].size() == 0);
      return {9'd0, 7'(txq[c].size()), 1'b0, 7'(rxq[c].size()), 2'b00,
              unf[c], ovf[c], rxe, rxf, txe, txf};
   endfunction

   // One clock: predict from current inputs, advance, compare after the edge
   task automatic cycle();
      logic        exp_ack;
      logic [31:0] exp_dat;
      bit          acc, hit, hpop, hpush, any_irq;
      int          ch, r;
      exp_ack = 1'b0;
      exp_dat = 32'h0;
      for (int c = 0; c < NCH; c++)
         if (host_tx_valid[c] === 1'b1 && host_tx_ready[c])
            dut_got[c].push_back(host_tx_data[32*c +: 32]);
      if (ext_rst) begin
         for (int c = 0; c < NCH; c++) begin
            txq[c].delete(); rxq[c].delete();
            ovf[c] = 0; unf[c] = 0; ien[c] = 0;
         end
      end else begin
         acc = wb_cyc && wb_stb;
         ch  = int'(wb_adr[4:2]);
         r   = int'(wb_adr[1:0]);
         exp_ack = acc;
         if (acc && !wb_we && ch < NCH) begin
            case (r)
               1: exp_dat = (rxq[ch].size() > 0) ? rxq[ch][0] : 32'h0;
               2: exp_dat = exp_status(ch);
               3: exp_dat = {31'd0, ien[ch]};
               default: exp_dat = 32'h0;
            endcase
         end
         for (int c = 0; c < NCH; c++) begin
            hpop  = (txq[c].size() > 0) && host_tx_ready[c];
            hpush = (rxq[c].size() < DEP) && host_rx_valid[c];
            hit   = acc && (ch == c);
            if (hit && wb_we && r == 3 && wb_dat_w[1]) begin
               txq[c].delete();
               rxq[c].delete();
            end else begin
               if (hpop) void'(txq[c].pop_front());
               if (hit && wb_we && r == 0) begin
                  if (txq[c].size() < DEP) txq[c].push_back(wb_dat_w);
                  else ovf[c] = 1;
               end
               if (hit && !wb_we && r == 1) begin
                  if (rxq[c].size() > 0) void'(rxq[c].pop_front());
                  else unf[c] = 1;
               end
               if (hpush) rxq[c].push_back(host_rx_data[32*c +: 32]);
            end
            if (hit && wb_we && r == 3) begin
               ien[c] = wb_dat_w[0];
               if (wb_dat_w[2]) begin ovf[c] = 0; unf[c] = 0; end
            end
         end
      end
      @(posedge ext_clk);
      #1;
      check("ack", 32'(wb_ack), 32'(exp_ack));
      check("rdata", wb_dat_r, exp_dat);
      check("stall", 32'(wb_stall), 32'h0);
      if (wb_ack) begin last_rd = wb_dat_r; ack_cnt++; end
      any_irq = 0;
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("tx_valid%0d", c), 32'(host_tx_valid[c]), 32'(txq[c].size() > 0));
         check($sformatf("rx_ready%0d", c), 32'(host_rx_ready[c]), 32'(rxq[c].size() < DEP));
         if (txq[c].size() > 0)
            check($sformatf("tx_data%0d", c), host_tx_data[32*c +: 32], txq[c][0]);
         if (ien[c] && rxq[c].size() > 0) any_irq = 1;
      end
      check("irq", 32'(irq), 32'(any_irq));
   endtask

   task automatic set_bus(input bit we, input int ch, input int r, input logic [31:0] d);
      wb_cyc = 1; wb_stb = 1; wb_we = we;
      wb_adr = {25'd0, 3'(ch), 2'(r)};
      wb_dat_w = d;
   endtask

   task automatic idle();
      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_dat_w = 32'h0;
   endtask

   task automatic rand_access();
      int r;
      wb_we  = 1'($urandom);
      r      = int'($urandom_range(0, 3));
      wb_adr = {25'($urandom), 3'($urandom), 2'(r)};
      wb_dat_w = $urandom;
      if (r == 3 && ($urandom % 8) != 0) wb_dat_w[1] = 1'b0;
   endtask

   initial begin
      ext_rst = 1; wb_sel = 4'hF; idle(); wb_adr = '0;
      host_tx_ready = '0; host_rx_valid = '0; host_rx_data = '0;
      last_rd = '0;
      cycle(); cycle();
      ext_rst = 0;
      cycle();

      // Reset state: STATUS of channel 0, ack exactly one cycle later
      set_bus(0, 0, 2, 0); cycle();
      check("reset_status", wb_dat_r, 32'h0000_000A);
      idle(); cycle();
      check("ack_one_cycle", 32'(wb_ack), 32'h0);

      // TX overflow on ch1
      for (int i = 0; i < 9; i++) begin set_bus(1, 1, 0, 32'(i + 1)); cycle(); end
      set_bus(0, 1, 2, 0); cycle();
      check("ovf_status", wb_dat_r, 32'h0008_0019);
      idle();
      dut_got[1].delete();
      host_tx_ready[1] = 1;
      for (int i = 0; i < 10; i++) cycle();
      check("ovf_got_n", 32'(dut_got[1].size()), 32'd8);
      for (int i = 0; i < 8; i++) check("ovf_order", dut_got[1][i], 32'(i + 1));
      host_tx_ready[1] = 0;
      set_bus(1, 1, 3, 32'h4); cycle();
      idle(); cycle();

      // RX interrupt on ch2
      set_bus(1, 2, 3, 32'h1); cycle();
      idle(); cycle();
      check("irq_idle", 32'(irq), 32'h0);
      host_rx_valid[2] = 1; host_rx_data[64 +: 32] = 32'hDEAD_BEEF; cycle();
      host_rx_valid[2] = 0;
      check("irq_rise", 32'(irq), 32'h1);
      set_bus(0, 2, 1, 0); cycle();
      check("rx_deadbeef", wb_dat_r, 32'hDEAD_BEEF);
      check("irq_fall", 32'(irq), 32'h0);
      idle(); cycle();

      // TX push with simultaneous host pop while full (ch0)
      for (int i = 0; i < 8; i++) begin set_bus(1, 0, 0, 32'h100 + 32'(i)); cycle(); end
      dut_got[0].delete();
      set_bus(1, 0, 0, 32'h200); host_tx_ready[0] = 1; cycle();
      host_tx_ready[0] = 0;
      set_bus(0, 0, 2, 0); cycle();
      check("full_pop_status", wb_dat_r, 32'h0008_0009);
      idle(); host_tx_ready[0] = 1;
      for (int i = 0; i < 10; i++) cycle();
      host_tx_ready[0] = 0;
      check("full_pop_n", 32'(dut_got[0].size()), 32'd9);
      for (int i = 0; i < 8; i++) check("full_pop_order", dut_got[0][i], 32'h100 + 32'(i));
      check("full_pop_last", dut_got[0][8], 32'h200);

      // Empty RX read with simultaneous host push (ch3)
      set_bus(0, 3, 1, 0); host_rx_valid[3] = 1; host_rx_data[96 +: 32] = 32'h55; cycle();
      host_rx_valid[3] = 0;
      check("unf_read", wb_dat_r, 32'h0);
      set_bus(0, 3, 2, 0); cycle();
      check("unf_status", wb_dat_r, 32'h0000_0122);
      set_bus(1, 3, 3, 32'h4); cycle();
      set_bus(0, 3, 2, 0); cycle();
      check("unf_cleared", wb_dat_r, 32'h0000_0102);
      set_bus(0, 3, 1, 0); cycle();
      check("rx_drain", wb_dat_r, 32'h55);

      // Flush racing host transfers on ch1
      set_bus(1, 1, 0, 32'hA1); cycle();
      set_bus(1, 1, 0, 32'hA2); cycle();
      set_bus(1, 1, 3, 32'h2); host_rx_valid[1] = 1; host_tx_ready[1] = 1; cycle();
      host_rx_valid[1] = 0; host_tx_ready[1] = 0;
      set_bus(0, 1, 2, 0); cycle();
      check("flush_status", wb_dat_r, 32'h0000_000A);

      // Out-of-range channel
      set_bus(1, 7, 0, 32'h1234); cycle();
      set_bus(0, 7, 2, 0); cycle();
      check("ch7_ack", 32'(wb_ack), 32'h1);
      check("ch7_data", wb_dat_r, 32'h0);

      // 16-access burst
      ack_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         wb_cyc = 1; wb_stb = 1; rand_access(); cycle();
      end
      idle(); cycle();
      check("burst_acks", 32'(ack_cnt), 32'd16);

      // Reset during an accepted access
      set_bus(0, 0, 2, 0); ext_rst = 1; cycle();
      ext_rst = 0; idle(); cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         wb_cyc = ($urandom % 4) != 0;
         wb_stb = ($urandom % 4) != 0;
         rand_access();
         host_tx_ready = NCH'($urandom);
         host_rx_valid = NCH'($urandom);
         for (int c = 0; c < NCH; c++) host_rx_data[32*c +: 32] = $urandom;
         cycle();
      end
      idle(); host_rx_valid = '0; cycle();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/microwatt_ext_io_mailbox.md
# microwatt_ext_io_mailbox

Multi-channel debug mailbox that terminates Microwatt's `wb_ext_io` Wishbone port instead of tying it off. It gives firmware `NUM_CH` bidirectional 32-bit FIFO channels to the external debugger logic. Each channel has one CPU→host FIFO (TX) and one host→CPU FIFO (RX). Per-channel status, sticky error flags and an RX interrupt are provided, and all interrupts are ORed onto `ext_irq_eth`, which is otherwise unused.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels, 1..8.
- `FIFO_DEPTH`, default 8: entries per FIFO; a power of 2, 2..64.
- `CNT_W`, default `$clog2(FIFO_DEPTH)+1`: width of the occupancy counters (derived; do not override).

Ports (all signals belong to the single clock domain; reset is synchronous and active-high):
- `ext_clk`  in  1  system clock.
- `ext_rst`  in  1  synchronous, active-high reset.
- `wb_adr`  in  30  word address; bits [4:2] select the channel, bits [1:0] select the register.
- `wb_dat_w`  in  32  write data.
- `wb_sel`  in  4  byte selects; any nonzero value is treated as a full-word access.
- `wb_cyc`, `wb_stb`, `wb_we`  in  1 each  Wishbone pipelined master controls.
- `wb_dat_r`  out  32  read data.
- `wb_ack`  out  1  access acknowledge.
- `wb_stall`  out  1  tied to 0.
- `host_tx_data`  out  `NUM_CH*32`  CPU→host data; channel c occupies bits [32c+31:32c].
- `host_tx_valid`  out  `NUM_CH`  per-channel TX valid.
- `host_tx_ready`  in  `NUM_CH`  per-channel TX ready.
- `host_rx_data`  in  `NUM_CH*32`  host→CPU data.
- `host_rx_valid`  in  `NUM_CH`  per-channel RX valid.
- `host_rx_ready`  out  `NUM_CH`  per-channel RX ready.
- `irq`  out  1  OR of all enabled channel interrupts; connects to `ext_irq_eth`.

## Operation
Register map per channel, selected by `adr[1:0]`:
- 0 TXDATA (write-only): a write pushes `wb_dat_w` onto TX. If TX is full, the data is dropped and sticky `tx_ovf` is set.
- 1 RXDATA (read-only): a read pops RX and returns its head. If RX is empty, the read returns 0 and sets sticky `rx_unf`.
- 2 STATUS (read-only):
  - bit 0 `tx_full`, bit 1 `tx_empty`, bit 2 `rx_full`, bit 3 `rx_empty`;
  - bit 4 `tx_ovf`, bit 5 `rx_unf`;
  - bits [14:8] `rx_count`, bits [22:16] `tx_count`, each zero-extended.
- 3 CTRL (read/write):
  - bit 0 `rx_irq_en`, read/write.
  - bit 1 `flush`, write-1 only, reads as 0: empties both FIFOs of the channel in the cycle the write is accepted.
  - bit 2 write-1 clears `tx_ovf` and `rx_unf`.
- Wrong-direction accesses (a write to RXDATA or STATUS, a read of TXDATA): no side effect; the read returns 0.
- Accesses to a channel index ≥ `NUM_CH` are acked with data 0 and have no side effect, so the bus never hangs.
- Channel interrupt = `rx_irq_en & !rx_empty`. `irq` is the OR of all channel interrupts.
- Host TX side: `host_tx_valid = !tx_empty`, `host_tx_data` = TX head. A transfer happens on `valid & ready`.
- Host RX side: `host_rx_ready = !rx_full`. A transfer happens on `valid & ready`.

## Timing
- An access is accepted in cycle N when `wb_cyc & wb_stb`. `wb_ack` goes high in cycle N+1 for exactly one cycle, and `wb_dat_r` is valid in that same cycle.
- Back-to-back accesses are accepted every cycle, so throughput is one access per cycle.
- All FIFO side effects (push, pop, flush, sticky-flag updates) take effect at the N→N+1 clock edge. STATUS returns the state as it was in cycle N.
- When `wb_cyc` is low, no access is accepted. An ack already pending for a previous accepted access is still issued.
- Simultaneous TX push and host pop when TX is full:
  - The push is accepted and the count is unchanged.
  - Full is evaluated after the pop, so `tx_ovf` is not set.
- Simultaneous RX pop and host push when RX is empty:
  - The read returns 0 and `rx_unf` is set.
  - The host word is stored, and `rx_count` becomes 1.
- Flush and a host transfer in the same cycle: flush wins, and the host word is discarded. The host side still sees the handshake as completed.
- Occupancy counters saturate naturally because full and empty are guarded. Read and write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`.
- Reset values:
  - `wb_ack`=0, `wb_dat_r`=0;
  - all FIFOs empty, so `host_tx_valid`=0 and `host_rx_ready`=all ones;
  - `rx_irq_en`=0, sticky flags =0, `irq`=0.
- Reset in the middle of an access: the pending ack is dropped and the FIFO contents are lost.

## Structure
- Shared package `microwatt_mbox_pkg` holds:
  - register offsets (`MBOX_TXDATA`, `MBOX_RXDATA`, `MBOX_STATUS`, `MBOX_CTRL`);
  - status and control bit positions;
  - `MBOX_MAX_CH` = 8.
- Sub-module `mbox_sync_fifo`: parameters for data width and depth; inputs push, pop, flush; outputs data, count, full, empty. It is instantiated 2×`NUM_CH` times.
- The top level contains the address decode, the ack/read-data register, the per-channel control registers and the IRQ OR.
- `microwatt_wrapper` instantiates this block on the `wb_ext_io` port in place of the tie-offs.

## Test plan
- Reset, then read STATUS of channel 0 → `0x0000_000A` (both FIFOs empty), with ack exactly 1 cycle after acceptance.
- Write 9 words to ch1 TXDATA with `FIFO_DEPTH`=8 and `host_tx_ready`=0:
  - STATUS shows `tx_full`, `tx_ovf` and `tx_count`=8.
  - Then raise ready: the host receives words 1–8 in order, the 9th is absent.
- Host pushes `0xDEADBEEF` on ch2 with `rx_irq_en`=1:
  - `irq` rises one cycle after the transfer.
  - A read of RXDATA returns `0xDEADBEEF`, and `irq` falls one cycle after the read is accepted.
- With TX full, issue a TX write in the same cycle as a host pop → count stays 8, `tx_ovf`=0, FIFO order preserved.
- Read an empty RX while the host pushes in the same cycle → read returns 0, `rx_unf`=1, `rx_count`=1. A CTRL write of `0x4` then clears `rx_unf`.
- Access channel 7 with `NUM_CH`=4 → acked, data 0. Then a back-to-back burst of 16 mixed accesses → 16 acks with no stall.
